// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory-slave FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_SPLIT = 2'b10,
    HRESP_RETRY = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE    = 3'd0,
    HSIZE_HALF    = 3'd1,
    HSIZE_WORD    = 3'd2,
    HSIZE_DWORD   = 3'd3,
    HSIZE_BIT128  = 3'd4,
    HSIZE_BIT256  = 3'd5,
    HSIZE_BIT512  = 3'd6,
    HSIZE_BIT1024 = 3'd7
  } hsize_e;

  // Memory-slave FSM; ST_ERR2 is the second, ready-high cycle of ERROR.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/ahb_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) stepped only when enabled.
module ahb_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_hclk,
  input  logic        i_hreset_n,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic feedback;
  assign feedback = o_state[15] ^ o_state[13] ^ o_state[12] ^ o_state[10];

  // Shift left, feeding the tap XOR into bit 0.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) o_state <= SEED;
    else if (i_en)   o_state <= {o_state[14:0], feedback};
  end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: byte-lane writes, fixed or LFSR-chosen wait states,
// two-cycle ERROR for out-of-range, oversized or misaligned transfers.
//
// Handshake: an address phase is taken when i_hready & i_hsel & htrans is
// NONSEQ/SEQ at a rising edge; the data phase ends at the first rising edge
// where o_hready is 1 (write data sampled there, read data valid during it).
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int DATA_WDT    = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int WAIT_RANDOM = 0
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output logic [1:0]          o_hresp,
  output ahb_state_e          o_dbg_state
);

  localparam int BYTES = DATA_WDT / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);

  // Lanes covered by a transfer of 2^size bytes starting at byte offset off.
  function automatic logic [BYTES-1:0] lane_en(input logic [OFF_W-1:0] off,
                                               input logic [2:0] size);
    logic [BYTES-1:0] en;
    int lo;
    int hi;
    en = '0;
    lo = int'(off);
    hi = lo + (1 << size);
    for (int i = 0; i < BYTES; i++) en[i] = (i >= lo) && (i < hi);
    return en;
  endfunction

  ahb_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             wr_q;
  logic [AW-1:0]    idx_q;
  logic [BYTES-1:0] be_q;
  logic [15:0]      lfsr_q;
  logic [DATA_WDT-1:0] rd_word;

  logic       accept;
  logic       legal;
  logic       capture;
  logic [3:0] wait_cnt;
  logic [6:0] align_mask;
  logic       commit;

  assign accept     = i_hready & i_hsel & i_htrans[1];
  assign align_mask = (7'd1 << i_hsize) - 7'd1;
  assign legal      = ~(|(i_haddr >> (OFF_W + AW)))
                    & (i_hsize <= 3'(OFF_W))
                    & ~(|(i_haddr[6:0] & align_mask));
  assign commit     = (state_q == ST_DATA) & wr_q;

  ahb_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_hclk     (i_hclk),
    .i_hreset_n (i_hreset_n),
    .i_en       (capture & legal),
    .o_state    (lfsr_q)
  );

  // Wait count for the transfer being accepted this cycle.
  always_comb begin
    wait_cnt = 4'(WAIT_STATES);
    if (WAIT_RANDOM != 0)
      wait_cnt = 4'({1'b0, lfsr_q[3:0]} % 5'(WAIT_STATES + 1));
  end

  // Next-state, wait counter and per-state bus response.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    o_hready = 1'b1;
    o_hresp  = HRESP_OKAY;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (state_q == ST_ERR2) o_hresp = HRESP_ERROR;
        if (accept) begin
          capture = 1'b1;
          if (!legal) begin
            state_d = ST_ERR1;
          end else if (wait_cnt == 4'd0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = wait_cnt;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        o_hready = 1'b0;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DATA;
      end
      ST_ERR1: begin
        o_hready = 1'b0;
        o_hresp  = HRESP_ERROR;
        state_d  = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and captured address-phase information.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        wr_q  <= i_hwrite & legal;
        idx_q <= i_haddr[OFF_W +: AW];
        be_q  <= lane_en(i_haddr[OFF_W-1:0], i_hsize);
      end
    end
  end

  // One byte column per lane so partial writes leave other lanes intact.
  for (genvar b = 0; b < BYTES; b++) begin : g_lane
    logic [7:0] col [DEPTH];
    // Lane write at the edge that completes a write data phase.
    always_ff @(posedge i_hclk) begin
      if (commit && be_q[b]) col[idx_q] <= i_hwdata[8*b +: 8];
    end
    assign rd_word[8*b +: 8] = col[idx_q];
  end

  // Read data is driven only during a read data phase.
  always_comb begin
    o_hrdata = '0;
    if ((state_q == ST_DATA) && !wr_q) o_hrdata = rd_word;
  end

  assign o_dbg_state = state_q;

  logic unused_ok;
  assign unused_ok = ^{i_hburst, lfsr_q[15:4]};

endmodule

// File: doc/ahb_mem_slave.md
# ahb_mem_slave

Parametrised AHB-Lite memory slave: a synthesisable, bench-reusable successor to the simple AHB slave model used in the master bench. It supports configurable data width and depth, HSIZE byte-lane writes, and fixed or pseudo-random wait states. Out-of-range and illegal transfers receive the two-cycle ERROR response. It sits behind the decoder as a default target for master verification and as a scratch RAM.

## Interface
- DATA_WDT, 32: data bus width; one of 32, 64, 128.
- DEPTH, 1024: memory depth in DATA_WDT-wide words; power of two.
- WAIT_STATES, 0: maximum wait states per transfer, 0..15.
- WAIT_RANDOM, 0: 0 inserts exactly WAIT_STATES per transfer; 1 inserts LFSR-chosen 0..WAIT_STATES.
- i_hclk  in  1  bus clock; all logic on its rising edge.
- i_hreset_n  in  1  reset, asynchronous, active-low.
- i_hsel  in  1  slave select.
- i_haddr  in  32  byte address.
- i_htrans  in  2  IDLE/BUSY/NONSEQ/SEQ.
- i_hwrite  in  1  1 = write.
- i_hsize  in  3  transfer size (BYTE..BIT1024).
- i_hburst  in  3  accepted and ignored; each beat is decoded individually.
- i_hwdata  in  DATA_WDT  write data, valid in the data phase.
- i_hready  in  1  bus HREADY; qualifies the address phase.
- o_hrdata  out  DATA_WDT  read data.
- o_hready  out  1  HREADYOUT.
- o_hresp  out  2  OKAY=0, ERROR=1.

## Operation
- **Address phase accept:** i_hready & i_hsel & (i_htrans==NONSEQ | i_htrans==SEQ) at a rising edge. Capture addr, write, size, and legality.
- **Illegal transfer**, any of:
  - word index i_haddr/(DATA_WDT/8) ≥ DEPTH;
  - 8·2^hsize > DATA_WDT;
  - i_haddr not aligned to 2^hsize.
- **IDLE/BUSY/unselected** transfers: zero-wait OKAY, no state change.
- **FSM states:** ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2.
  - ST_IDLE/ST_DATA + legal accept with wait count 0 → ST_DATA.
  - ST_IDLE/ST_DATA + legal accept with wait count > 0 → ST_WAIT, loading the counter.
  - ST_IDLE/ST_DATA + illegal accept → ST_ERR1.
  - ST_IDLE/ST_DATA + no accept → ST_IDLE.
  - ST_WAIT: decrement the counter; at 1 → ST_DATA.
  - ST_ERR1 → ST_ERR2.
  - ST_ERR2 behaves as ST_DATA for the next accept.
- **Outputs per state:**
  - ST_IDLE: o_hready=1, o_hresp=OKAY.
  - ST_WAIT: o_hready=0, OKAY.
  - ST_DATA: o_hready=1, OKAY.
  - ST_ERR1: o_hready=0, ERROR.
  - ST_ERR2: o_hready=1, ERROR.
- **Writes:** commit at the rising edge ending ST_DATA. Byte lanes are enabled little-endian from addr[log2(DATA_WDT/8)-1:0] and size; other lanes are unchanged.
- **Reads:** o_hrdata = mem[word index] (full word, all lanes) while in ST_DATA with a read pending; otherwise 0.
- **Read-after-write:** a read accepted in the same cycle a write completes sees the new data, because the read is serviced in the following data phase.
- **Wait count:**
  - WAIT_RANDOM=0: count = WAIT_STATES.
  - WAIT_RANDOM=1: count = lfsr[3:0] mod (WAIT_STATES+1).
  - The 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances once per legal accept.
- **Memory** is not reset.

## Timing
- **Reset values** (all asynchronous to i_hreset_n low):
  - o_hready=1, o_hresp=OKAY, o_hrdata=0;
  - FSM=ST_IDLE, counter=0, LFSR=16'hACE1, pending write discarded.
- **Legal transfer accepted at edge N:** o_hready=0 in cycles N+1..N+W; data phase completes at edge N+W+1 with o_hready=1.
- **Back-to-back:** the next address is accepted at the completing edge. Zero-wait throughput is one beat per cycle.
- **Error:** cycle N+1 o_hready=0/ERROR, cycle N+2 o_hready=1/ERROR. No memory update. WAIT_STATES does not apply.
- **Accepts** are only possible while o_hready=1, since i_hready follows o_hready when this slave is selected.

## Structure
- **ahb_pkg** holds shared localparams and typedefs, reused by master and bench:
  - htrans (IDLE/BUSY/NONSEQ/SEQ);
  - hresp (OKAY/ERROR/SPLIT/RETRY);
  - hburst codes;
  - hsize codes;
  - FSM state enum.
- **ahb_lfsr16** is a sub-module: enable and seed parameter in, 16-bit state out.
- The memory is an array of DATA_WDT/8 byte columns for lane writes.

## Test plan
- **Reset behaviour:** hold i_hreset_n low, toggle the clock → o_hready=1, o_hresp=0, o_hrdata=0; deassert → still idle.
- **Zero-wait round trip:** WAIT_STATES=0. NONSEQ write 0xDEADBEEF @0x10, then NONSEQ read @0x10 back-to-back → read data phase returns 0xDEADBEEF; o_hready never low.
- **Byte-lane write:** write 0x11223344 @0x20, then BYTE write 0xAA @0x22 (data on lane 2) → read @0x20 returns 0x11AA3344.
- **Fixed wait states:** WAIT_STATES=3, WAIT_RANDOM=0, INCR4 burst @0x40 → each beat shows exactly 3 o_hready-low cycles; 4 beats complete in 16 cycles.
- **Error response:** DEPTH=1024, read @0x1000, then WORD read @0x2 → each gets ERROR for 2 cycles (hready 0 then 1); a following legal write completes OKAY.
- **Reset mid-operation:** WAIT_RANDOM=1, WAIT_STATES=7, random traffic checked against a scoreboard. Assert reset during ST_WAIT → o_hready=1 immediately and the write is not committed.
